// File: rtl/energy_manager.sv
// Energy budget controller: spends energy on request, regenerates over time,
// and enforces a cooldown period after the budget is fully depleted.
module energy_manager #(
  parameter int MAX_ENERGY      = 10,
  parameter int REGEN_CYCLES    = 50_000_000,
  parameter int COOLDOWN_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        use_req,
  input  logic [3:0]  use_cost,
  input  logic        refill,
  output logic [10:0] energy,
  output logic        use_ack,
  output logic        use_deny,
  output logic        depleted,
  output logic [1:0]  level
);

  localparam logic [0:0] ST_ACTIVE   = 1'b0;
  localparam logic [0:0] ST_COOLDOWN = 1'b1;

  // Counters are 27 bits, so all cycle parameters must lie in 1..2^27-1.
  localparam logic [10:0] MAX_E      = 11'(MAX_ENERGY);
  localparam logic [26:0] REGEN_LAST = 27'(REGEN_CYCLES - 1);
  localparam logic [26:0] COOL_LAST  = 27'(COOLDOWN_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [10:0] energy_q, energy_d;
  logic [26:0] regen_q, regen_d;
  logic [26:0] cool_q, cool_d;
  logic        ack_q, ack_d;
  logic        deny_q, deny_d;

  logic [10:0] cost_ext;
  logic        afford;
  logic        grant;

  assign cost_ext = {7'd0, use_cost};
  assign afford   = (cost_ext <= energy_q);
  // A zero-cost request is acknowledged but does not count as a spend.
  assign grant    = use_req && (state_q == ST_ACTIVE) && afford && (use_cost != 4'd0);

  always_comb begin
    state_d  = state_q;
    energy_d = energy_q;
    regen_d  = regen_q;
    cool_d   = cool_q;
    ack_d    = 1'b0;
    deny_d   = 1'b0;

    if (refill) begin
      state_d  = ST_ACTIVE;
      energy_d = MAX_E;
      regen_d  = '0;
      cool_d   = '0;
      deny_d   = use_req;
    end else begin
      if (use_req) begin
        if ((state_q == ST_ACTIVE) && afford) ack_d = 1'b1;
        else                                  deny_d = 1'b1;
      end

      // A spend preempts regeneration on the same edge; a denial does not.
      if (grant) begin
        energy_d = energy_q - cost_ext;
        regen_d  = '0;
        if (energy_q == cost_ext) begin
          state_d = ST_COOLDOWN;
          cool_d  = '0;
        end
      end else if (state_q == ST_COOLDOWN) begin
        if (cool_q == COOL_LAST) begin
          state_d = ST_ACTIVE;
          cool_d  = '0;
          regen_d = '0;
        end else begin
          cool_d = cool_q + 27'd1;
        end
      end else if (energy_q < MAX_E) begin
        if (regen_q == REGEN_LAST) begin
          energy_d = energy_q + 11'd1;
          regen_d  = '0;
        end else begin
          regen_d = regen_q + 27'd1;
        end
      end else begin
        regen_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_ACTIVE;
      energy_q <= MAX_E;
      regen_q  <= '0;
      cool_q   <= '0;
      ack_q    <= 1'b0;
      deny_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      energy_q <= energy_d;
      regen_q  <= regen_d;
      cool_q   <= cool_d;
      ack_q    <= ack_d;
      deny_q   <= deny_d;
    end
  end

  always_comb begin
    if (energy_q > 11'd6)      level = 2'd2;
    else if (energy_q > 11'd3) level = 2'd1;
    else                       level = 2'd0;
  end

  assign energy   = energy_q;
  assign use_ack  = ack_q;
  assign use_deny = deny_q;
  assign depleted = (state_q == ST_COOLDOWN);

endmodule

// File: tb/tb_energy_manager.sv
// Scoreboard bench for energy_manager: stimulus queues expected snapshots per
// edge, a monitor on the falling edge pops and compares them.
module tb_energy_manager;

  logic        clk;
  logic        reset;
  logic        use_req;
  logic [3:0]  use_cost;
  logic        refill;
  logic [10:0] energy;
  logic        use_ack;
  logic        use_deny;
  logic        depleted;
  logic [1:0]  level;

  energy_manager #(
    .MAX_ENERGY(10),
    .REGEN_CYCLES(4),
    .COOLDOWN_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .use_req(use_req),
    .use_cost(use_cost),
    .refill(refill),
    .energy(energy),
    .use_ack(use_ack),
    .use_deny(use_deny),
    .depleted(depleted),
    .level(level)
  );

  typedef struct {
    int    cyc;
    int    ack;
    int    deny;
    int    en;
    int    dep;
    int    lvl;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input int cost);
    use_req  = req;
    use_cost = 4'(cost);
  endtask

  task automatic expect_at(input int c, input int a, input int d, input int en,
                           input int dep, input int lvl, input string nm);
    exp_t e;
    e.cyc = c; e.ack = a; e.deny = d; e.en = en; e.dep = dep; e.lvl = lvl; e.name = nm;
    q.push_back(e);
  endtask

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        check({e.name, "_missed"}, 1, 0);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check({e.name, "_ack"},      int'(use_ack),  e.ack);
        check({e.name, "_deny"},     int'(use_deny), e.deny);
        check({e.name, "_energy"},   int'(energy),   e.en);
        check({e.name, "_depleted"}, int'(depleted), e.dep);
        check({e.name, "_level"},    int'(level),    e.lvl);
      end else begin
        check("unexpected_pulse", int'(use_ack | use_deny), 0);
      end
      if (done || cyc > 1000) begin
        if (!done) check("timeout", 1, 0);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    int c, g, h, d, f, r;
    reset = 1'b0;
    refill = 1'b0;
    drive(1'b0, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    expect_at(cyc, 0, 0, 10, 0, 2, "post_reset");

    // zero-cost request at full energy
    drive(1'b1, 0);
    c = cyc + 1;
    expect_at(c, 1, 0, 10, 0, 2, "ack_cost0");
    tick();
    drive(1'b0, 0);

    // spend 3 then regenerate back to full
    drive(1'b1, 3);
    g = cyc + 1;
    expect_at(g,      1, 0, 7,  0, 2, "spend3");
    expect_at(g + 1,  0, 0, 7,  0, 2, "spend3_end");
    expect_at(g + 3,  0, 0, 7,  0, 2, "regen_wait");
    expect_at(g + 4,  0, 0, 8,  0, 2, "regen_first");
    expect_at(g + 8,  0, 0, 9,  0, 2, "regen_second");
    expect_at(g + 11, 0, 0, 9,  0, 2, "regen_wait2");
    expect_at(g + 12, 0, 0, 10, 0, 2, "regen_full");
    expect_at(g + 16, 0, 0, 10, 0, 2, "hold_max");
    tick();
    drive(1'b0, 0);
    repeat (16) tick();

    // down to 4, over-spend, then spend on the regen edge
    drive(1'b1, 6);
    h = cyc + 1;
    expect_at(h, 1, 0, 4, 0, 1, "spend6");
    tick();
    drive(1'b1, 5);
    expect_at(h + 1, 0, 1, 4, 0, 1, "overspend");
    expect_at(h + 3, 0, 0, 4, 0, 1, "overspend_wait");
    expect_at(h + 4, 0, 0, 5, 0, 1, "regen_after_deny");
    tick();
    drive(1'b0, 0);
    repeat (6) tick();
    drive(1'b1, 2);
    expect_at(h + 8,  1, 0, 3, 0, 0, "spend_on_regen");
    expect_at(h + 11, 0, 0, 3, 0, 0, "regen_edge_wait");
    expect_at(h + 12, 0, 0, 4, 0, 1, "regen_after_edge_spend");
    tick();
    drive(1'b0, 0);
    repeat (4) tick();

    // depletion with request held through cooldown
    drive(1'b1, 4);
    d = cyc + 1;
    expect_at(d, 1, 0, 0, 1, 0, "deplete");
    for (int i = 1; i <= 7; i++) expect_at(d + i, 0, 1, 0, 1, 0, "cool_deny");
    expect_at(d + 8,  0, 1, 0, 0, 0, "cool_exit");
    expect_at(d + 11, 0, 0, 0, 0, 0, "cool_regen_wait");
    expect_at(d + 12, 0, 0, 1, 0, 0, "regen_after_cool");
    tick();
    repeat (8) tick();
    drive(1'b0, 0);
    repeat (4) tick();

    // refill during cooldown with a concurrent request
    drive(1'b1, 1);
    f = cyc + 1;
    expect_at(f,     1, 0, 0, 1, 0, "deplete2");
    expect_at(f + 1, 0, 0, 0, 1, 0, "cool_idle");
    tick();
    drive(1'b0, 0);
    tick();
    tick();
    refill = 1'b1;
    drive(1'b1, 2);
    expect_at(f + 3, 0, 1, 10, 0, 2, "refill_cool");
    expect_at(f + 4, 0, 0, 10, 0, 2, "refill_end");
    expect_at(f + 7, 0, 0, 10, 0, 2, "full_hold");
    tick();
    refill = 1'b0;
    drive(1'b0, 0);
    repeat (4) tick();

    // asynchronous reset in the middle of cooldown
    drive(1'b1, 10);
    r = cyc + 1;
    expect_at(r, 1, 0, 0, 1, 0, "deplete3");
    tick();
    drive(1'b0, 0);
    repeat (3) tick();
    #1;
    reset = 1'b0;
    expect_at(cyc, 0, 0, 10, 0, 2, "async_reset");
    #6;
    reset = 1'b1;
    drive(1'b1, 9);
    expect_at(r + 4, 1, 0, 1, 0, 0, "grant_after_reset");
    expect_at(r + 8, 0, 0, 2, 0, 0, "regen_after_reset");
    tick();
    drive(1'b0, 0);
    repeat (4) tick();
    done = 1'b1;
  end

endmodule
